// File: rtl/label_table_pointer_register_pkg.sv
// Shared widths, label type codes and entry layouts for the label table / pointer register block.
package label_table_pointer_register_pkg;

    localparam int unsigned LBID_W = 12;
    localparam int unsigned OFS_W  = 16;
    localparam int unsigned PIDX_W = 6;
    localparam int unsigned TYPE_W = 8;

    typedef logic [TYPE_W-1:0] lbtype_t;

    // New label types are added here only.
    localparam lbtype_t LBTYPE_UNDEFINED = 8'h00;
    localparam lbtype_t LBTYPE_CODE      = 8'h01;

    typedef struct packed {
        lbtype_t          typ;
        logic [OFS_W-1:0] base;
        logic [OFS_W-1:0] count;
    } lbt_data_t;

    typedef struct packed {
        logic [LBID_W-1:0] lbid;
        logic [OFS_W-1:0]  ofs;
    } preg_entry_t;

endpackage

// File: rtl/label_table.sv
// Label table: one entry per label ID, combinational read, invalid entries read as undefined/0/0.
module label_table
    import label_table_pointer_register_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LBID_W-1:0] rd_lbid_i,
    input  logic [LBID_W-1:0] wr_lbid_i,
    input  lbt_data_t         wr_data_i,
    input  logic              we_i,
    output lbt_data_t         rd_data_o
);

    localparam int unsigned Depth = 1 << LBID_W;

    logic [Depth-1:0] valid_q;
    lbt_data_t        mem_q [Depth];

    // Only the valid bits need clearing; payload is masked until rewritten.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_lbid_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i && !rst_i) begin
            mem_q[wr_lbid_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o     = '0;
        rd_data_o.typ = LBTYPE_UNDEFINED;
        if (valid_q[rd_lbid_i]) begin
            rd_data_o = mem_q[rd_lbid_i];
        end
    end

endmodule

// File: rtl/pointer_register.sv
// Pointer register file: 64 x {lbid, ofs}, two independent combinational read ports.
module pointer_register
    import label_table_pointer_register_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PIDX_W-1:0] rd_idx0_i,
    input  logic [PIDX_W-1:0] rd_idx1_i,
    input  logic [PIDX_W-1:0] wr_idx_i,
    input  preg_entry_t       wr_data_i,
    input  logic              we_i,
    output preg_entry_t       rd_data0_o,
    output preg_entry_t       rd_data1_o
);

    localparam int unsigned Depth = 1 << PIDX_W;

    preg_entry_t regs_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data0_o = regs_q[rd_idx0_i];
    assign rd_data1_o = regs_q[rd_idx1_i];

endmodule

// File: rtl/label_table_pointer_register.sv
// Top: label table plus pointer register file, two fully independent stores.
module label_table_pointer_register
    import label_table_pointer_register_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LBID_W-1:0] lbt_lbid_i,
    input  logic [LBID_W-1:0] lbt_lbidw_i,
    input  logic [TYPE_W-1:0] lbt_typw_i,
    input  logic [OFS_W-1:0]  lbt_basew_i,
    input  logic [OFS_W-1:0]  lbt_countw_i,
    input  logic              lbt_we_i,
    output logic [TYPE_W-1:0] lbt_typ_o,
    output logic [OFS_W-1:0]  lbt_base_o,
    output logic [OFS_W-1:0]  lbt_count_o,
    input  logic [PIDX_W-1:0] preg_p0_i,
    input  logic [PIDX_W-1:0] preg_p1_i,
    input  logic [PIDX_W-1:0] preg_pw_i,
    input  logic [LBID_W-1:0] preg_lbidw_i,
    input  logic [OFS_W-1:0]  preg_ofsw_i,
    input  logic              preg_we_i,
    output logic [LBID_W-1:0] preg_lbid0_o,
    output logic [OFS_W-1:0]  preg_ofs0_o,
    output logic [LBID_W-1:0] preg_lbid1_o,
    output logic [OFS_W-1:0]  preg_ofs1_o
);

    lbt_data_t   lbt_wr_data, lbt_rd_data;
    preg_entry_t preg_wr_data, preg_rd0, preg_rd1;

    assign lbt_wr_data  = '{typ: lbt_typw_i, base: lbt_basew_i, count: lbt_countw_i};
    assign preg_wr_data = '{lbid: preg_lbidw_i, ofs: preg_ofsw_i};

    label_table u_label_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_lbid_i (lbt_lbid_i),
        .wr_lbid_i (lbt_lbidw_i),
        .wr_data_i (lbt_wr_data),
        .we_i      (lbt_we_i),
        .rd_data_o (lbt_rd_data)
    );

    pointer_register u_pointer_register (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx0_i  (preg_p0_i),
        .rd_idx1_i  (preg_p1_i),
        .wr_idx_i   (preg_pw_i),
        .wr_data_i  (preg_wr_data),
        .we_i       (preg_we_i),
        .rd_data0_o (preg_rd0),
        .rd_data1_o (preg_rd1)
    );

    assign lbt_typ_o    = lbt_rd_data.typ;
    assign lbt_base_o   = lbt_rd_data.base;
    assign lbt_count_o  = lbt_rd_data.count;
    assign preg_lbid0_o = preg_rd0.lbid;
    assign preg_ofs0_o  = preg_rd0.ofs;
    assign preg_lbid1_o = preg_rd1.lbid;
    assign preg_ofs1_o  = preg_rd1.ofs;

endmodule

// File: tb/tb_label_table_pointer_register.sv
// Directed and randomized checks of label_table_pointer_register against an array model.
module tb_label_table_pointer_register;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lbt_lbid = '0, lbt_lbidw = '0;
    logic [7:0]  lbt_typw = '0;
    logic [15:0] lbt_basew = '0, lbt_countw = '0;
    logic        lbt_we = 1'b0;
    logic [7:0]  lbt_typ;
    logic [15:0] lbt_base, lbt_count;
    logic [5:0]  preg_p0 = '0, preg_p1 = '0, preg_pw = '0;
    logic [11:0] preg_lbidw = '0;
    logic [15:0] preg_ofsw = '0;
    logic        preg_we = 1'b0;
    logic [11:0] preg_lbid0, preg_lbid1;
    logic [15:0] preg_ofs0, preg_ofs1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain arrays of what each location should hold.
    bit          m_valid [4096];
    logic [7:0]  m_typ   [4096];
    logic [15:0] m_base  [4096];
    logic [15:0] m_count [4096];
    logic [11:0] m_plbid [64];
    logic [15:0] m_pofs  [64];

    always #5 clk = ~clk;

    label_table_pointer_register dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lbt_lbid_i   (lbt_lbid),
        .lbt_lbidw_i  (lbt_lbidw),
        .lbt_typw_i   (lbt_typw),
        .lbt_basew_i  (lbt_basew),
        .lbt_countw_i (lbt_countw),
        .lbt_we_i     (lbt_we),
        .lbt_typ_o    (lbt_typ),
        .lbt_base_o   (lbt_base),
        .lbt_count_o  (lbt_count),
        .preg_p0_i    (preg_p0),
        .preg_p1_i    (preg_p1),
        .preg_pw_i    (preg_pw),
        .preg_lbidw_i (preg_lbidw),
        .preg_ofsw_i  (preg_ofsw),
        .preg_we_i    (preg_we),
        .preg_lbid0_o (preg_lbid0),
        .preg_ofs0_o  (preg_ofs0),
        .preg_lbid1_o (preg_lbid1),
        .preg_ofs1_o  (preg_ofs1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_plbid[i] = '0;
            m_pofs[i]  = '0;
        end
    endtask

    // Compare every output against the model, or against zero while in reset.
    task automatic check_all(input string tag);
        logic [7:0]  et;
        logic [15:0] eb, ec;
        if (rst || !m_valid[lbt_lbid]) begin
            et = 8'h00; eb = '0; ec = '0;
        end else begin
            et = m_typ[lbt_lbid]; eb = m_base[lbt_lbid]; ec = m_count[lbt_lbid];
        end
        chk({tag, ".typ"},   {24'd0, lbt_typ},   {24'd0, et});
        chk({tag, ".base"},  {16'd0, lbt_base},  {16'd0, eb});
        chk({tag, ".count"}, {16'd0, lbt_count}, {16'd0, ec});
        chk({tag, ".lbid0"}, {20'd0, preg_lbid0}, rst ? 32'd0 : {20'd0, m_plbid[preg_p0]});
        chk({tag, ".ofs0"},  {16'd0, preg_ofs0},  rst ? 32'd0 : {16'd0, m_pofs[preg_p0]});
        chk({tag, ".lbid1"}, {20'd0, preg_lbid1}, rst ? 32'd0 : {20'd0, m_plbid[preg_p1]});
        chk({tag, ".ofs1"},  {16'd0, preg_ofs1},  rst ? 32'd0 : {16'd0, m_pofs[preg_p1]});
    endtask

    // Advance one rising edge, mirroring any enabled write in the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (lbt_we) begin
                m_valid[lbt_lbidw] = 1'b1;
                m_typ[lbt_lbidw]   = lbt_typw;
                m_base[lbt_lbidw]  = lbt_basew;
                m_count[lbt_lbidw] = lbt_countw;
            end
            if (preg_we) begin
                m_plbid[preg_pw] = preg_lbidw;
                m_pofs[preg_pw]  = preg_ofsw;
            end
        end
        #1;
    endtask

    initial begin
        model_clear();
        for (int i = 0; i < 4096; i++) begin
            m_typ[i] = '0; m_base[i] = '0; m_count[i] = '0;
        end

        // Reset held: outputs zero, writes ignored.
        #3;
        check_all("reset");
        lbt_we = 1'b1; lbt_lbidw = 12'd7; lbt_typw = 8'h55; lbt_basew = 16'h1234;
        lbt_countw = 16'h4321; preg_we = 1'b1; preg_pw = 6'd7; preg_lbidw = 12'h777;
        preg_ofsw = 16'h7777; lbt_lbid = 12'd7; preg_p0 = 6'd7;
        tick();
        check_all("reset_wr_ignored");
        rst = 1'b0;
        #1;
        check_all("post_reset");
        lbt_we = 1'b0; preg_we = 1'b0;

        // First edge after reset: label 3 = {CODE, 2, 6}.
        lbt_we = 1'b1; lbt_lbidw = 12'd3; lbt_typw = 8'h01; lbt_basew = 16'd2; lbt_countw = 16'd6;
        tick();
        lbt_we = 1'b0;
        lbt_lbid = 12'd0; #1;
        chk("lbl0.typ", {24'd0, lbt_typ}, 32'h0);
        chk("lbl0.count", {16'd0, lbt_count}, 32'h0);
        lbt_lbid = 12'd3; #1;
        chk("lbl3.typ", {24'd0, lbt_typ}, 32'h01);
        chk("lbl3.base", {16'd0, lbt_base}, 32'd2);
        chk("lbl3.count", {16'd0, lbt_count}, 32'd6);

        // Pointer 4 = {3, 2}, chained into the label table.
        preg_we = 1'b1; preg_pw = 6'd4; preg_lbidw = 12'd3; preg_ofsw = 16'd2;
        tick();
        preg_we = 1'b0; preg_p0 = 6'd4; preg_p1 = 6'd4; #1;
        chk("p4.lbid0", {20'd0, preg_lbid0}, 32'd3);
        chk("p4.ofs0", {16'd0, preg_ofs0}, 32'd2);
        chk("p4.lbid1", {20'd0, preg_lbid1}, 32'd3);
        chk("p4.ofs1", {16'd0, preg_ofs1}, 32'd2);
        lbt_lbid = preg_lbid0; #1;
        chk("chain.base", {16'd0, lbt_base}, 32'd2);
        chk("chain.count", {16'd0, lbt_count}, 32'd6);

        // we=0 with changing address/data leaves storage alone.
        for (int i = 0; i < 3; i++) begin
            lbt_lbidw = 12'd3; lbt_typw = 8'($urandom); lbt_basew = 16'($urandom);
            preg_pw = 6'd4; preg_lbidw = 12'($urandom); preg_ofsw = 16'($urandom);
            tick();
        end
        lbt_lbid = 12'd3; preg_p0 = 6'd4; preg_p1 = 6'd4; #1;
        check_all("we0_hold");

        // Extreme indices and all-ones data.
        lbt_we = 1'b1; lbt_lbidw = 12'hFFF; lbt_typw = 8'hFF; lbt_basew = 16'hFFFF;
        lbt_countw = 16'hFFFF; preg_we = 1'b1; preg_pw = 6'd63; preg_lbidw = 12'hFFF;
        preg_ofsw = 16'hFFFF;
        tick();
        lbt_we = 1'b0; preg_we = 1'b0;
        lbt_lbid = 12'hFFF; preg_p0 = 6'd63; preg_p1 = 6'd62; #1;
        chk("lbl4095.typ", {24'd0, lbt_typ}, 32'hFF);
        chk("lbl4095.base", {16'd0, lbt_base}, 32'hFFFF);
        chk("p63.lbid0", {20'd0, preg_lbid0}, 32'hFFF);
        chk("p63.ofs0", {16'd0, preg_ofs0}, 32'hFFFF);
        check_all("max_idx");
        lbt_lbid = 12'hFFE; preg_p1 = 6'd0; #1;
        check_all("max_neighbours");

        // Mid-cycle asynchronous reset.
        lbt_lbid = 12'd3; preg_p0 = 6'd4; preg_p1 = 6'd4;
        #2 rst = 1'b1;
        model_clear();
        #1;
        check_all("async_rst");
        #1 rst = 1'b0;
        #1;
        chk("rst_lbl3.base", {16'd0, lbt_base}, 32'd0);
        chk("rst_p4.lbid0", {20'd0, preg_lbid0}, 32'd0);
        check_all("after_rst");

        // Read-during-write on pointer 5.
        preg_we = 1'b1; preg_pw = 6'd5; preg_lbidw = 12'h0AA; preg_ofsw = 16'h1111;
        tick();
        preg_p0 = 6'd5; preg_lbidw = 12'h0BB; preg_ofsw = 16'h2222; #1;
        chk("rdw.old", {16'd0, preg_ofs0}, 32'h1111);
        tick();
        preg_we = 1'b0;
        chk("rdw.new", {16'd0, preg_ofs0}, 32'h2222);

        // Random traffic over a small address window so reads hit written entries.
        for (int i = 0; i < 400; i++) begin
            lbt_we     = 1'($urandom);
            lbt_lbidw  = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
            lbt_typw   = 8'($urandom);
            lbt_basew  = 16'($urandom);
            lbt_countw = 16'($urandom);
            preg_we    = 1'($urandom);
            preg_pw    = 6'($urandom_range(0, 7));
            preg_lbidw = 12'($urandom);
            preg_ofsw  = 16'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                model_clear();
                #1;
                check_all("rnd_rst");
                rst = 1'b0;
            end
            tick();
            lbt_lbid = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
            preg_p0  = 6'($urandom_range(0, 7));
            preg_p1  = ($urandom_range(0, 3) == 0) ? preg_p0 : 6'($urandom_range(0, 7));
            #1;
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/label_table_pointer_register.md
LABEL_TABLE_POINTER_REGISTER -- requirements
Module: label_table_pointer_register

Interface
REQ-001 Parameters: LBID_W 12 (label ID width); OFS_W 16 (offset/base/count width); PIDX_W 6 (pointer register index width); TYPE_W 8 (label type width).
REQ-002 clk  input  1  sole clock; all writes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 lbt_lbid  input  12  label table read address.
REQ-005 lbt_lbidw  input  12  label table write address.
REQ-006 lbt_typw / lbt_basew / lbt_countw  input  8/16/16  write data: type, base, count.
REQ-007 lbt_we  input  1  label table write enable.
REQ-008 lbt_typ / lbt_base / lbt_count  output  8/16/16  read data for lbt_lbid.
REQ-009 preg_p0 / preg_p1  input  6/6  pointer register read indices, ports 0 and 1.
REQ-010 preg_pw  input  6  pointer register write index.
REQ-011 preg_lbidw / preg_ofsw  input  12/16  pointer write data: label ID, offset.
REQ-012 preg_we  input  1  pointer register write enable.
REQ-013 preg_lbid0 / preg_ofs0  output  12/16  pointer contents at preg_p0.
REQ-014 preg_lbid1 / preg_ofs1  output  12/16  pointer contents at preg_p1.

Function
REQ-015 Label table SHALL hold 4096 entries {valid, typ[7:0], base[15:0], count[15:0]}, indexed by label ID.
REQ-016 On rising clk with lbt_we=1 and reset=0: entry[lbt_lbidw] <= {1, lbt_typw, lbt_basew, lbt_countw}.
REQ-017 Label table read SHALL be combinational: outputs follow lbt_lbid with no clock latency.
REQ-018 Reading an entry with valid=0 SHALL return typ=LBTYPE_UNDEFINED (0), base=0, count=0.
REQ-019 Pointer register file SHALL hold 64 entries {lbid[11:0], ofs[15:0]}.
REQ-020 On rising clk with preg_we=1 and reset=0: entry[preg_pw] <= {preg_lbidw, preg_ofsw}.
REQ-021 Both pointer read ports SHALL be combinational and independent; p0==p1 returns identical data on both ports.
REQ-022 Read-during-write to the same index SHALL return the old value before the edge and the new value immediately after it; no bypass.
REQ-023 we=0 SHALL leave storage unchanged whatever the address and data inputs.
REQ-024 The two stores SHALL be fully independent; simultaneous writes to both in one cycle SHALL both take effect.
REQ-025 Write data SHALL be stored unmodified; no range checking of count/ofs against base.

Reset
REQ-026 reset=1 SHALL asynchronously clear every label table valid bit.
REQ-027 reset=1 SHALL asynchronously clear every pointer entry to lbid=0, ofs=0.
REQ-028 While reset=1, writes SHALL be ignored and all outputs SHALL read 0.
REQ-029 The first write SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package SHALL hold the width constants and label type codes: LBTYPE_UNDEFINED=8'h00, LBTYPE_CODE=8'h01; further types are added there only.
REQ-031 Top SHALL instantiate two sub-modules: label_table (REQ-015..018) and pointer_register (REQ-019..021).
REQ-032 Address arithmetic (base+ofs) is out of scope; it belongs to the downstream memory controller.

Verification
REQ-033 Write lbidw=3, typ=LBTYPE_CODE, base=2, count=6, we for one edge; read lbid=0 -> 0/0/0; read lbid=3 -> 0x01/2/6.
REQ-034 Write pw=4, lbidw=3, ofsw=2; p0=4 -> lbid0=3, ofs0=2; p1=4 -> identical; lbid0 fed to lbt_lbid -> base=2, count=6.
REQ-035 Drive new address/data with we=0 for several edges -> both stores unchanged.
REQ-036 Write pointer 63 {0xFFF, 0xFFFF} and label 4095 {0xFF, 0xFFFF, 0xFFFF}; read back exact values, neighbours unchanged.
REQ-037 After REQ-033/034, pulse reset mid-cycle -> outputs 0 immediately, without a clock edge; lbid=3 and p0=4 read 0 afterwards.
REQ-038 Write pw=5 while p0=5 -> ofs0 shows the old value before the edge and the new value right after it.
